// File: rtl/fetch_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module   : constants (package)
// Brief    : Shared widths and the fetch sequencer state encoding for the
//            19-bit CPU instruction fetch path.
// Revision : 1.0 - initial release
// ============================================================================
package constants;

  // Instruction word width of the 19-bit CPU
  localparam int WORD_SIZE      = 19;

  // Width of the optional performance counters
  localparam int PERF_CNT_WIDTH = 32;

  // Fetch sequencer states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    WAIT   = 3'd2,
    VALID  = 3'd3,
    HALTED = 3'd4
  } fetch_state_t;

endpackage : constants
`default_nettype wire

// File: rtl/fetch_controller_perf_counter.sv
`default_nettype none
// ============================================================================
// Module   : fetch_perf_counter
// Brief    : Saturating event counter with enable. Clears only on reset and
//            sticks at all-ones once full.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_perf_counter
  import constants::*;
#(
  parameter int WIDTH = PERF_CNT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count
);

  localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_count;

  // Count enabled events, holding at the maximum value instead of wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_en && (r_count != '1)) begin
      r_count <= r_count + C_ONE;
    end
  end

  assign o_count = r_count;

endmodule : fetch_perf_counter
`default_nettype wire

// File: rtl/fetch_controller.sv
`default_nettype none
// ============================================================================
// Module   : fetch_controller
// Brief    : Instruction fetch sequencer. Owns the PC, issues one-cycle reads
//            to instruction memory (1-cycle synchronous read), captures the
//            word into an instruction register and hands it to decode with a
//            valid/ready handshake. Accepts redirects and halts from execute.
// Options  : FETCH_PERF_CNT_EN - adds fetch_count / stall_count outputs.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_controller
  import constants::*;
#(
  parameter int                    ADDR_WIDTH   = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  halt_req,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_addr,
  output logic                  im_rd_en,
  output logic [ADDR_WIDTH-1:0] im_addr,
  input  logic [WORD_SIZE-1:0]  im_rdata,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [WORD_SIZE-1:0]  instr_out,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [PERF_CNT_WIDTH-1:0] fetch_count,
  output logic [PERF_CNT_WIDTH-1:0] stall_count
`endif
);

  localparam logic [ADDR_WIDTH-1:0] C_PC_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  fetch_state_t          r_state;
  fetch_state_t          w_state_next;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] w_pc_next;
  logic [ADDR_WIDTH-1:0] w_pc_inc;
  logic [WORD_SIZE-1:0]  r_instr_out;
  logic [ADDR_WIDTH-1:0] r_instr_pc;
  logic                  w_capture;

  // Wraps naturally modulo 2^ADDR_WIDTH
  assign w_pc_inc = r_pc + C_PC_ONE;

  // State, PC and instruction register updates
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_pc        <= '0;
      r_instr_out <= '0;
      r_instr_pc  <= '0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      if (w_capture) begin
        r_instr_out <= im_rdata;
        r_instr_pc  <= r_pc;
      end
    end
  end

  // Next-state and PC selection; halt beats redirect beats normal flow
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_capture    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_pc_next    = RESET_VECTOR;
          w_state_next = REQ;
        end
      end
      REQ: begin
        // A halt here leaves pc alone so the read is reissued on resume
        if (halt_req) begin
          w_state_next = HALTED;
        end else if (redirect_valid) begin
          w_pc_next    = redirect_addr;
          w_state_next = REQ;
        end else begin
          w_state_next = WAIT;
        end
      end
      WAIT: begin
        // Halt or redirect discard the returning word without capturing it
        if (halt_req) begin
          w_state_next = HALTED;
        end else if (redirect_valid) begin
          w_pc_next    = redirect_addr;
          w_state_next = REQ;
        end else begin
          w_capture    = 1'b1;
          w_pc_next    = w_pc_inc;
          w_state_next = VALID;
        end
      end
      VALID: begin
        if (halt_req) begin
          // An unconsumed word is refetched on resume by rewinding pc
          if (!instr_ready) begin
            w_pc_next = r_instr_pc;
          end
          w_state_next = HALTED;
        end else if (redirect_valid) begin
          w_pc_next    = redirect_addr;
          w_state_next = REQ;
        end else if (instr_ready) begin
          w_state_next = REQ;
        end
      end
      HALTED: begin
        if (start) begin
          w_state_next = REQ;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Outputs decode from registered state only, so they cannot glitch on inputs
  assign im_rd_en    = (r_state == REQ);
  assign im_addr     = (r_state == REQ) ? r_pc : '0;
  assign instr_valid = (r_state == VALID);
  assign halted      = (r_state == HALTED);
  assign instr_out   = r_instr_out;
  assign instr_pc    = r_instr_pc;

`ifdef FETCH_PERF_CNT_EN
  logic w_fetch_evt;
  logic w_stall_evt;

  assign w_fetch_evt = instr_valid && instr_ready;
  assign w_stall_evt = instr_valid && !instr_ready;

  fetch_perf_counter #(
    .WIDTH (PERF_CNT_WIDTH)
  ) u_fetch_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_fetch_evt),
    .o_count (fetch_count)
  );

  fetch_perf_counter #(
    .WIDTH (PERF_CNT_WIDTH)
  ) u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_stall_evt),
    .o_count (stall_count)
  );
`else
  // Performance counters are not built in this configuration
`endif

endmodule : fetch_controller
`default_nettype wire

// File: tb/tb_fetch_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_controller
// Brief    : Self-checking bench for fetch_controller with a 1-cycle
//            synchronous instruction memory model and a scoreboard of the
//            words decode is expected to see.
// Options  : FETCH_PERF_CNT_EN - also checks the performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_controller;
  import constants::*;

  typedef struct packed {
    logic [WORD_SIZE-1:0] w;
    logic [15:0]          pc;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic                 halt_req;
  logic                 redirect_valid;
  logic [15:0]          redirect_addr;
  logic                 im_rd_en;
  logic [15:0]          im_addr;
  logic [WORD_SIZE-1:0] im_rdata = '0;
  logic                 instr_valid;
  logic                 instr_ready;
  logic [WORD_SIZE-1:0] instr_out;
  logic [15:0]          instr_pc;
  logic                 halted;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]          fetch_count;
  logic [31:0]          stall_count;
`endif

  logic [WORD_SIZE-1:0] mem [0:65535];
  exp_t                 sb_q[$];
  exp_t                 mon_e;
  logic                 prev_valid = 1'b0;
  logic [WORD_SIZE-1:0] held_w = '0;
  logic [15:0]          held_pc = '0;
  int                   n_vec = 0;
  int                   n_err = 0;
  int                   e;

  always #5 clk = ~clk;

  fetch_controller #(
    .ADDR_WIDTH   (16),
    .RESET_VECTOR (16'h0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .halt_req       (halt_req),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .im_rd_en       (im_rd_en),
    .im_addr        (im_addr),
    .im_rdata       (im_rdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_out      (instr_out),
    .instr_pc       (instr_pc),
    .halted         (halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count    (fetch_count),
    .stall_count    (stall_count)
`endif
  );

  // Memory returns data the cycle after a read; garbage otherwise
  always @(posedge clk) begin
    im_rdata <= im_rd_en ? mem[im_addr] : 19'h7FFFF;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [WORD_SIZE-1:0] w, input logic [15:0] pc);
    exp_t x;
    x.w  = w;
    x.pc = pc;
    sb_q.push_back(x);
  endtask

  // Step edges until instr_valid is seen, bounded
  task automatic wait_valid(output int edges);
    edges = 0;
    do begin
      @(posedge clk);
      #1;
      edges++;
    end while (!instr_valid && edges < 20);
    if (!instr_valid) chk("valid_timeout", {31'd0, instr_valid}, 32'd1);
  endtask

  // From VALID with ready high: REQ to address a, WAIT, then VALID
  task automatic next_fetch(input logic [15:0] a);
    @(posedge clk); #1;
    chk("nf_rd_en", {31'd0, im_rd_en}, 32'd1);
    chk("nf_addr", {16'd0, im_addr}, {16'd0, a});
    @(posedge clk); #1;
    chk("nf_wait_rd_en", {31'd0, im_rd_en}, 32'd0);
    @(posedge clk); #1;
    chk("nf_valid", {31'd0, instr_valid}, 32'd1);
  endtask

  // Scoreboard monitor: every new presentation must match the queue head,
  // and a held word must stay stable
  always @(negedge clk) begin
    if (rst) begin
      prev_valid <= 1'b0;
    end else begin
      if (instr_valid && !prev_valid) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_word", sb_q.size(), 32'd1);
        end else begin
          mon_e = sb_q.pop_front();
          chk("sb_word", {13'd0, instr_out}, {13'd0, mon_e.w});
          chk("sb_pc", {16'd0, instr_pc}, {16'd0, mon_e.pc});
        end
        held_w  <= instr_out;
        held_pc <= instr_pc;
      end else if (instr_valid) begin
        chk("hold_word", {13'd0, instr_out}, {13'd0, held_w});
        chk("hold_pc", {16'd0, instr_pc}, {16'd0, held_pc});
      end
      prev_valid <= instr_valid;
    end
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = '0;
    mem[0]       = 19'h12340;
    mem[1]       = 19'h0ABCD;
    mem[2]       = 19'h05678;
    mem[3]       = 19'h1EFF0;
    mem[16'hFFFF] = 19'h00001;

    rst = 1'b1; start = 1'b0; halt_req = 1'b0; redirect_valid = 1'b0;
    redirect_addr = '0; instr_ready = 1'b0;
    #2;
    chk("rst_rd_en", {31'd0, im_rd_en}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_instr_out", {13'd0, instr_out}, 32'd0);
    chk("rst_instr_pc", {16'd0, instr_pc}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_fetch_cnt", fetch_count, 32'd0);
    chk("rst_stall_cnt", stall_count, 32'd0);
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_rd_en", {31'd0, im_rd_en}, 32'd0);
    chk("idle_addr", {16'd0, im_addr}, 32'd0);

    // Basic fetch, ready held high
    push(19'h12340, 16'd0); push(19'h0ABCD, 16'd1);
    push(19'h05678, 16'd2); push(19'h1EFF0, 16'd3);
    instr_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("req_rd_en", {31'd0, im_rd_en}, 32'd1);
    wait_valid(e);
    chk("lat_start", e + 1, 32'd3);
    for (int k = 1; k < 4; k++) begin
      wait_valid(e);
      chk("throughput", e, 32'd3);
    end
    @(negedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;

    // Backpressure on the first word
    instr_ready = 1'b0;
    push(19'h12340, 16'd0);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_valid(e);
    chk("lat_bp", e + 1, 32'd3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_word", {13'd0, instr_out}, 32'h12340);
      chk("bp_rd_en", {31'd0, im_rd_en}, 32'd0);
      chk("bp_valid", {31'd0, instr_valid}, 32'd1);
      @(posedge clk); #1;
    end
`ifdef FETCH_PERF_CNT_EN
    chk("stall_cnt", stall_count, 32'd5);
    chk("fetch_cnt0", fetch_count, 32'd0);
`endif
    instr_ready = 1'b1;
    push(19'h0ABCD, 16'd1);
    next_fetch(16'd1);
`ifdef FETCH_PERF_CNT_EN
    chk("fetch_cnt1", fetch_count, 32'd1);
`endif

    // Redirect while the read for address 2 is in flight
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("in_wait_rd_en", {31'd0, im_rd_en}, 32'd0);
    redirect_valid = 1'b1; redirect_addr = 16'd3;
    @(posedge clk); #1 redirect_valid = 1'b0;
    chk("redir_rd_en", {31'd0, im_rd_en}, 32'd1);
    chk("redir_addr", {16'd0, im_addr}, 32'd3);
    push(19'h1EFF0, 16'd3);
    wait_valid(e);
    chk("redir_lat", e, 32'd2);

    // Halt in VALID, unconsumed word at address 2
    instr_ready = 1'b0;
    redirect_valid = 1'b1; redirect_addr = 16'd2;
    push(19'h05678, 16'd2);
    @(posedge clk); #1 redirect_valid = 1'b0;
    wait_valid(e);
    halt_req = 1'b1;
    @(posedge clk); #1 halt_req = 1'b0;
    chk("halted", {31'd0, halted}, 32'd1);
    chk("halt_valid", {31'd0, instr_valid}, 32'd0);
    chk("halt_rd_en", {31'd0, im_rd_en}, 32'd0);
    repeat (2) @(posedge clk);
    #1 chk("halted_hold", {31'd0, halted}, 32'd1);
    push(19'h05678, 16'd2);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("resume_halted", {31'd0, halted}, 32'd0);
    chk("resume_addr", {16'd0, im_addr}, 32'd2);
    wait_valid(e);
    chk("resume_lat", e, 32'd2);

    // Wrap from all-ones to zero
    instr_ready = 1'b1;
    redirect_valid = 1'b1; redirect_addr = 16'hFFFF;
    push(19'h00001, 16'hFFFF);
    @(posedge clk); #1 redirect_valid = 1'b0;
    chk("wrap_addr", {16'd0, im_addr}, 32'h0000FFFF);
    wait_valid(e);
    push(19'h12340, 16'd0);
    next_fetch(16'd0);

    // Asynchronous reset mid-cycle while in WAIT
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst = 1'b1;
    #1;
    chk("arst_rd_en", {31'd0, im_rd_en}, 32'd0);
    chk("arst_addr", {16'd0, im_addr}, 32'd0);
    chk("arst_valid", {31'd0, instr_valid}, 32'd0);
    chk("arst_halted", {31'd0, halted}, 32'd0);
    chk("arst_instr_out", {13'd0, instr_out}, 32'd0);
    chk("arst_instr_pc", {16'd0, instr_pc}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("arst_fetch_cnt", fetch_count, 32'd0);
`endif
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_no_valid", {31'd0, instr_valid}, 32'd0);
    end
    push(19'h12340, 16'd0);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_valid(e);
    chk("restart_lat", e + 1, 32'd3);
    @(negedge clk); #1;
    chk("sb_drained", sb_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_fetch_controller
`default_nettype wire
